// File: rtl/dual_alu4_macro.sv
// Two parallel 4-bit ALUs whose flags and results are packed into one 15-bit output register.
// Optional macro DUAL_ALU4_PARITY_EN puts even parity over OUT[13:0] into OUT[14].
module dual_alu4_macro (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    logic [14:0] out_q;
    logic [14:0] out_d;
    logic [6:0]  alu0;
    logic [6:0]  alu1;

    // Returns {v, z, c, r[3:0]}; C is carry for add and borrow for subtract.
    function automatic logic [6:0] alu4(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] sel);
        logic [4:0] wide;
        logic [3:0] r;
        logic       c;
        logic       v;
        wide = '0;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (sel)
            2'b00: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[3:0];
                c    = wide[4];
                v    = (a[3] == b[3]) && (r[3] != a[3]);
            end
            2'b01: begin
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[3:0];
                c    = wide[4];
                v    = (a[3] != b[3]) && (r[3] != a[3]);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return {v, (r == 4'd0), c, r};
    endfunction

    always_comb begin
        alu0 = alu4(io_in[21:18], io_in[25:22], io_in[35:34]);
        alu1 = alu4(io_in[29:26], io_in[33:30], io_in[37:36]);
        out_d        = '0;
        out_d[0]     = alu0[4];
        out_d[1]     = alu0[5];
        out_d[2]     = alu0[6];
        out_d[6:3]   = alu0[3:0];
        out_d[10:7]  = alu1[3:0];
        out_d[11]    = alu1[4];
        out_d[12]    = alu1[5];
        out_d[13]    = alu1[6];
`ifdef DUAL_ALU4_PARITY_EN
        out_d[14]    = ^out_d[13:0];
`else
        out_d[14]    = 1'b0;
`endif
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) out_q <= '0;
        else          out_q <= out_d;
    end

    always_comb begin
        io_out       = '0;
        io_out[0]    = out_q[0];
        io_out[17:4] = out_q[14:1];
        io_oeb       = '1;
        io_oeb[0]    = 1'b0;
        io_oeb[17:4] = '0;
    end

endmodule

// File: tb/tb_dual_alu4_macro.sv
// Self-checking bench for dual_alu4_macro: directed spec vectors, async reset, and random
// vectors against an integer-arithmetic reference model (honours DUAL_ALU4_PARITY_EN).
module tb_dual_alu4_macro;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [37:0] io_in    = '0;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    logic [14:0] exp_out;
    logic [14:0] prev_out;

    localparam logic [37:0] OEB_EXP = {20'hFFFFF, 14'h0000, 3'b111, 1'b0};

`ifdef DUAL_ALU4_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    dual_alu4_macro dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Result in bits 3:0, C in bit 4, V in bit 5, computed with signed/unsigned integer arithmetic.
    function automatic int alu_ref(input int a, input int b, input int sel);
        int sa, sb, s, r, c, v;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        r = 0; c = 0; v = 0;
        case (sel)
            0: begin
                r = (a + b) % 16;
                c = (a + b > 15) ? 1 : 0;
                s = sa + sb;
                v = (s > 7 || s < -8) ? 1 : 0;
            end
            1: begin
                r = (a - b + 16) % 16;
                c = (a < b) ? 1 : 0;
                s = sa - sb;
                v = (s > 7 || s < -8) ? 1 : 0;
            end
            2: r = a & b;
            default: r = a | b;
        endcase
        return r + 16 * c + 32 * v;
    endfunction

    function automatic logic [14:0] model(input int a0, input int b0, input int s1,
                                          input int a1, input int b1, input int s2);
        int x0, x1;
        logic [14:0] o;
        x0 = alu_ref(a0, b0, s1);
        x1 = alu_ref(a1, b1, s2);
        o        = '0;
        o[0]     = x0[4];
        o[1]     = (x0[3:0] == 0);
        o[2]     = x0[5];
        o[6:3]   = x0[3:0];
        o[10:7]  = x1[3:0];
        o[11]    = x1[4];
        o[12]    = (x1[3:0] == 0);
        o[13]    = x1[5];
        o[14]    = PAR_ON ? ^o[13:0] : 1'b0;
        return o;
    endfunction

    function automatic logic [37:0] pads(input logic [14:0] o);
        logic [37:0] p;
        p       = '0;
        p[0]    = o[0];
        p[17:4] = o[14:1];
        return p;
    endfunction

    // Ignored io_in bits are filled with noise.
    task automatic drive(input int a0, input int b0, input int s1,
                         input int a1, input int b1, input int s2);
        logic [17:0] noise;
        noise = 18'($urandom);
        io_in = {2'(s2), 2'(s1), 4'(b1), 4'(a1), 4'(b0), 4'(a0), noise};
        exp_out = model(a0, b0, s1, a1, b1, s2);
    endtask

    initial begin
        drive(9, 9, 0, 0, 0, 0);
        #2;
        check("reset_out", io_out, '0);
        check("reset_oeb", io_oeb, OEB_EXP);
        repeat (2) @(posedge wb_clk_i);
        #1;
        check("reset_held", io_out, '0);

        @(negedge wb_clk_i) wb_rst_i = 1'b0;
        @(posedge wb_clk_i) #1;
        check("req018_const", io_out, pads(15'b001000000010101));
        check("req018_model", io_out, pads(exp_out));

        @(negedge wb_clk_i) drive(3, 5, 1, 0, 0, 0);
        @(posedge wb_clk_i) #1;
        check("req019_const", io_out, pads({PAR_ON, 14'b01000001110001}));

        @(negedge wb_clk_i) drive(0, 0, 0, 12, 10, 2);
        @(posedge wb_clk_i) #1;
        check("req020_const", io_out, pads(15'b000010000000010));

        @(negedge wb_clk_i) drive(7, 1, 0, 0, 0, 0);
        @(posedge wb_clk_i) #1;
        check("req021_const", io_out, pads({PAR_ON, 14'b01000001000100}));

        @(negedge wb_clk_i) drive(9, 9, 0, 0, 0, 0);
        @(posedge wb_clk_i) #1;
        check("pre_midreset", io_out, pads(15'b001000000010101));
        #1 wb_rst_i = 1'b1;
        #1;
        check("midreset_out", io_out, '0);
        check("midreset_oeb", io_oeb, OEB_EXP);
        @(negedge wb_clk_i) wb_rst_i = 1'b0;
        #1;
        check("post_release_hold", io_out, '0);
        @(posedge wb_clk_i) #1;
        check("post_release", io_out, pads(15'b001000000010101));
        prev_out = 15'b001000000010101;

        for (int i = 0; i < 300; i++) begin
            @(negedge wb_clk_i);
            drive(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(3)),
                  int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(3)));
            #1;
            check("latency_hold", io_out, pads(prev_out));
            @(posedge wb_clk_i) #1;
            check("random", io_out, pads(exp_out));
            if (i % 50 == 0) check("oeb_const", io_oeb, OEB_EXP);
            prev_out = exp_out;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
